// File: rtl/student_dma_pkg.sv
// Shared types and constants for the student sample DMA.
package student_dma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } dma_state_e;

    localparam logic [1:0] TL_SIZE_WORD = 2'd2;
    localparam logic [3:0] TL_MASK_FULL = 4'hF;

    // Ring index after idx; an index already past a shrunk ring wraps to 0.
    function automatic logic [15:0] next_idx(input logic [15:0] idx, input logic [15:0] len_eff);
        logic [16:0] inc;
        inc = {1'b0, idx} + 17'd1;
        return (inc >= {1'b0, len_eff}) ? 16'd0 : inc[15:0];
    endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel definitions for the student host port (32-bit data, 8-bit source).
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/student_sample_fifo.sv
// Synchronous first-word-fall-through FIFO; a pop in the same cycle frees room for a push when full.
module student_sample_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CNT_FULL);
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
            else if (do_pop && !do_push) cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/student_sample_dma.sv
// TL-UL host that writes buffered samples into a memory ring, one PutFullData outstanding at a time.
// Define STUDENT_SAMPLE_DMA_IRQ_EN to build the half-full / wrap interrupt pulse on irq_o.
module student_sample_dma import student_dma_pkg::*; #(
    parameter int unsigned SAMPLE_W   = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned SOURCE_ID  = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic [31:0]           base_addr_i,
    input  logic [15:0]           len_words_i,
    input  logic [SAMPLE_W-1:0]   sample_i,
    input  logic                  sample_valid_i,
    output logic [15:0]           wr_idx_o,
    output logic                  overflow_o,
    output logic                  err_o,
    input  logic                  clr_i,
    output logic                  irq_o,
    output tlul_pkg::tl_h2d_t     tl_host_o,
    input  tlul_pkg::tl_d2h_t     tl_host_i
);
    dma_state_e  state_q, state_d;
    logic [15:0] wr_idx_q, wr_idx_d, len_q, len_d, len_eff;
    logic [31:0] addr_q, addr_d, sample_ext, fifo_head;
    logic        ovf_q, ovf_d, err_q, err_d;
    logic        fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic        d_done, unused_inputs;

    assign len_eff    = (len_words_i == 16'd0) ? 16'd1 : len_words_i;
    assign sample_ext = 32'($signed(sample_i));
    assign fifo_push  = sample_valid_i && enable_i;
    assign d_done     = (state_q == WAIT) && tl_host_i.d_valid;
    assign unused_inputs = ^{base_addr_i[1:0], tl_host_i.d_opcode, tl_host_i.d_param, tl_host_i.d_size,
                             tl_host_i.d_source, tl_host_i.d_sink, tl_host_i.d_data};

    student_sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .data_i  (sample_ext),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty && enable_i) state_d = REQ;
            REQ:     if (tl_host_i.a_ready)       state_d = WAIT;
            WAIT:    if (tl_host_i.d_valid)       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tl_host_o           = '0;
        tl_host_o.a_valid   = (state_q == REQ);
        tl_host_o.a_opcode  = tlul_pkg::PutFullData;
        tl_host_o.a_param   = 3'd0;
        tl_host_o.a_size    = TL_SIZE_WORD;
        tl_host_o.a_source  = 8'(SOURCE_ID);
        tl_host_o.a_address = addr_q;
        tl_host_o.a_mask    = TL_MASK_FULL;
        tl_host_o.a_data    = fifo_head;
        tl_host_o.d_ready   = 1'b1;
        fifo_pop            = (state_q == REQ) && tl_host_i.a_ready;
        fifo_flush          = (state_q == IDLE) && !enable_i;
    end

    // Address and ring length are captured on entry to REQ so the request stays stable while stalled.
    always_comb begin
        addr_d   = addr_q;
        len_d    = len_q;
        wr_idx_d = wr_idx_q;
        if (state_q == IDLE && state_d == REQ) begin
            addr_d = {base_addr_i[31:2], 2'b00} + {14'd0, wr_idx_q, 2'b00};
            len_d  = len_eff;
        end
        if (d_done) wr_idx_d = next_idx(wr_idx_q, len_q);
        ovf_d = (fifo_push && fifo_full && !fifo_pop) || (ovf_q && !clr_i);
        err_d = (d_done && tl_host_i.d_error) || (err_q && !clr_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q   <= '0;
            len_q    <= 16'd1;
            wr_idx_q <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            len_q    <= len_d;
            wr_idx_q <= wr_idx_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign wr_idx_o   = wr_idx_q;
    assign overflow_o = ovf_q;
    assign err_o      = err_q;

`ifdef STUDENT_SAMPLE_DMA_IRQ_EN
    logic irq_q, irq_d, hit_half, hit_wrap;

    always_comb begin
        hit_wrap = (wr_idx_q == len_q - 16'd1);
        hit_half = (len_q >= 16'd2) && (wr_idx_q == (len_q >> 1) - 16'd1);
        irq_d    = d_done && (hit_wrap || hit_half);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_student_sample_dma.sv
// Directed bench with a memory responder and a write scoreboard for student_sample_dma.
module tb_student_sample_dma;
    import tlul_pkg::*;

    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          sample_valid = 1'b0;
    logic          clr = 1'b0;
    logic [31:0]   base = 32'h0001_0000;
    logic [15:0]   len = 16'd4;
    logic [SW-1:0] sample = '0;
    logic [15:0]   wr_idx;
    logic          overflow, err, irq;
    tl_h2d_t       tl_h;
    tl_d2h_t       tl_d;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q [$];
    bit stall = 0;
    int resp_delay = 1;
    int err_write = -1;
    int hs = 0, resps = 0, irq_cnt = 0, exp_irq_cnt = 0, m_idx = 0;

    student_sample_dma #(.SAMPLE_W(SW), .FIFO_DEPTH(8), .SOURCE_ID(0)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (enable),
        .base_addr_i    (base),
        .len_words_i    (len),
        .sample_i       (sample),
        .sample_valid_i (sample_valid),
        .wr_idx_o       (wr_idx),
        .overflow_o     (overflow),
        .err_o          (err),
        .clr_i          (clr),
        .irq_o          (irq),
        .tl_host_o      (tl_h),
        .tl_host_i      (tl_d)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int leff();
        return (len == 16'd0) ? 1 : int'(len);
    endfunction

    function automatic bit exp_irq(input int idx, input int le);
`ifdef STUDENT_SAMPLE_DMA_IRQ_EN
        return (idx == le - 1) || (le >= 2 && idx == le / 2 - 1);
`else
        return 1'b0;
`endif
    endfunction

    // Called on a falling edge; holds sample_valid for exactly one rising edge.
    task automatic push(input logic [SW-1:0] v, input bit acc);
        sample = v;
        sample_valid = 1'b1;
        if (acc) exp_q.push_back({{(32-SW){v[SW-1]}}, v});
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_resps(input int n, input int budget);
        int c = 0;
        while (resps < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("resp_count", resps, n);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    // Memory responder: owns the D channel and a_ready, scores every accepted write.
    initial begin
        bit          pend, pend_err, prev_stall, e;
        int          cnt;
        logic [31:0] prev_addr, prev_data, exp_data, exp_addr;
        pend = 0; pend_err = 0; prev_stall = 0; cnt = 0;
        prev_addr = '0; prev_data = '0;
        tl_d = '0;
        tl_d.d_opcode = AccessAck;
        tl_d.a_ready = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                pend = 0; prev_stall = 0;
                tl_d.d_valid = 1'b0; tl_d.d_error = 1'b0; tl_d.a_ready = !stall;
                continue;
            end
            if (irq === 1'b1) irq_cnt++;
            if (tl_d.d_valid) begin
                e = exp_irq(m_idx, leff());
                check("irq_on_resp", irq, e);
                exp_irq_cnt += int'(e);
                m_idx = (m_idx + 1 >= leff()) ? 0 : m_idx + 1;
                resps++;
                tl_d.d_valid = 1'b0;
                tl_d.d_error = 1'b0;
            end
            if (pend) begin
                if (cnt == 0) begin
                    check("d_ready", tl_h.d_ready, 1);
                    tl_d.d_valid = 1'b1;
                    tl_d.d_error = pend_err;
                    pend = 0;
                end else cnt--;
            end
            tl_d.a_ready = !stall;
            if (prev_stall) begin
                check("stall_valid_held", tl_h.a_valid, 1);
                check("stall_addr_stable", tl_h.a_address, prev_addr);
                check("stall_data_stable", tl_h.a_data, prev_data);
            end
            if (tl_h.a_valid && tl_d.a_ready) begin
                hs++;
                check("write_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_data = exp_q.pop_front();
                    exp_addr = {base[31:2], 2'b00} + 32'(m_idx) * 32'd4;
                    check("a_address", tl_h.a_address, exp_addr);
                    check("a_data", tl_h.a_data, exp_data);
                    check("a_mask", tl_h.a_mask, 4'hF);
                    check("a_size", tl_h.a_size, 2);
                    check("a_opcode", tl_h.a_opcode, 0);
                end
                pend = 1;
                cnt = resp_delay - 1;
                pend_err = (hs == err_write);
                prev_stall = 0;
            end else if (tl_h.a_valid) begin
                prev_stall = 1;
                prev_addr = tl_h.a_address;
                prev_data = tl_h.a_data;
            end else begin
                prev_stall = 0;
            end
        end
    end

    initial begin
        int c, irq_before;
        repeat (3) @(negedge clk);
        check("rst_a_valid", tl_h.a_valid, 0);
        check("rst_d_ready", tl_h.d_ready, 1);
        check("rst_wr_idx", wr_idx, 0);
        check("rst_overflow", overflow, 0);
        check("rst_err", err, 0);
        check("rst_irq", irq, 0);
        rst = 1'b0;
        enable = 1'b1;

        // Ring of 4 words, six samples: wraps once.
        for (int i = 1; i <= 6; i++) push(SW'(i), 1'b1);
        wait_resps(6, 100);
        check("t1_wr_idx", wr_idx, 2);
        check("t1_scoreboard_empty", exp_q.size(), 0);
        check("t1_overflow", overflow, 0);

        // Sign extension of a negative 16-bit sample.
        push(16'h8001, 1'b1);
        wait_resps(7, 50);
        check("sext_wr_idx", wr_idx, 3);

        // a_ready stalled: 10 samples, only 8 fit.
        stall = 1;
        for (int i = 0; i < 10; i++) push(SW'(16'h0100 + i), i < 8);
        repeat (10) @(negedge clk);
        check("stall_no_handshake", hs, 7);
        check("stall_overflow", overflow, 1);
        stall = 0;
        wait_resps(15, 200);
        repeat (10) @(negedge clk);
        check("stall_exact_writes", resps, 15);
        check("stall_wr_idx", wr_idx, 3);
        check("stall_scoreboard_empty", exp_q.size(), 0);
        pulse_clr();
        check("clr_overflow", overflow, 0);

        // Error response on the second write of this pair.
        err_write = hs + 2;
        push(SW'(16'h0011), 1'b1);
        push(SW'(16'h0022), 1'b1);
        wait_resps(17, 100);
        check("err_set", err, 1);
        check("err_wr_idx", wr_idx, 1);
        pulse_clr();
        check("err_clr", err, 0);

        // enable_i drops while the first of four queued writes is in WAIT.
        stall = 1;
        for (int i = 0; i < 4; i++) push(SW'(16'h0030 + i), 1'b1);
        repeat (4) @(negedge clk);
        resp_delay = 3;
        stall = 0;
        c = 0;
        while (hs < 18 && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("dis_handshake", hs, 18);
        enable = 1'b0;
        repeat (3) void'(exp_q.pop_back());
        repeat (12) @(negedge clk);
        check("dis_one_completion", resps, 18);
        check("dis_no_more_requests", hs, 18);
        check("dis_a_valid_low", tl_h.a_valid, 0);
        check("dis_wr_idx", wr_idx, 2);
        enable = 1'b1;
        repeat (10) @(negedge clk);
        check("dis_fifo_flushed", hs, 18);
        resp_delay = 1;
        push(SW'(16'h0042), 1'b1);
        wait_resps(19, 50);
        check("resume_wr_idx", wr_idx, 3);

        // Reset while idle, then a zero-length ring behaves as one word.
        rst = 1'b1;
        exp_q.delete();
        m_idx = 0;
        resps = 0;
        hs = 0;
        repeat (2) @(negedge clk);
        check("rst2_wr_idx", wr_idx, 0);
        check("rst2_a_valid", tl_h.a_valid, 0);
        rst = 1'b0;
        len = 16'd0;
        push(SW'(16'h0005), 1'b1);
        push(SW'(16'h0006), 1'b1);
        wait_resps(2, 60);
        check("len0_wr_idx", wr_idx, 0);

        // Interrupt behaviour over an 8-word ring and a 1-word ring.
        len = 16'd8;
        irq_before = irq_cnt;
        for (int i = 0; i < 8; i++) push(SW'(16'h0200 + i), 1'b1);
        wait_resps(10, 150);
        check("len8_wr_idx", wr_idx, 0);
`ifdef STUDENT_SAMPLE_DMA_IRQ_EN
        check("len8_irq_pulses", irq_cnt - irq_before, 2);
`else
        check("len8_irq_pulses", irq_cnt - irq_before, 0);
`endif
        len = 16'd1;
        irq_before = irq_cnt;
        for (int i = 0; i < 3; i++) push(SW'(16'h0300 + i), 1'b1);
        wait_resps(13, 80);
        check("len1_wr_idx", wr_idx, 0);
`ifdef STUDENT_SAMPLE_DMA_IRQ_EN
        check("len1_irq_pulses", irq_cnt - irq_before, 3);
`else
        check("len1_irq_pulses", irq_cnt - irq_before, 0);
`endif
        check("irq_total", irq_cnt, exp_irq_cnt);
        check("final_scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
